// File: rtl/rom_rd_pkg.sv
// Shared types and default parameters for the ROM burst reader.
package rom_rd_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ROM_LAT    = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef logic [DEF_ADDR_W:0] count_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// First-word-fall-through output buffer; head reads as zero when empty.
module rom_rd_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read initiator for a fixed-latency synchronous ROM, streaming over valid/ready.
// Define ROM_RD_CHECKSUM_EN to add the running checksum output of accepted words.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing ROM addresses while credits allow
// DRAIN | all addresses issued, waiting for the last word to be accepted
// DONE  | one-cycle completion pulse
module rom_burst_reader
  import rom_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROM_LAT    = DEF_ROM_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ROM_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W:0]    len_r;
  logic [ADDR_W:0]    issued;
  logic [ADDR_W:0]    delivered;
  logic [ROM_LAT-1:0] pipe;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W:0]     credit_used;
  logic               fifo_full;
  logic               fifo_empty;
  logic               start_ok;
  logic               issue;
  logic               pop;
  logic               last_issue;
  logic               last_pop;

  rom_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pipe[ROM_LAT-1]),
    .push_data (rom_q),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    inflight = '0;
    for (int k = 0; k < ROM_LAT; k++) inflight = inflight + CNT_W'(pipe[k]);
  end

  // Words in flight hold a FIFO slot in advance so a ROM return is never dropped.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign start_ok    = (state == IDLE) && start;
  assign issue       = (state == FETCH) && !fifo_full &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign last_issue  = issue && (issued == len_r - 1'b1);
  assign last_pop    = pop && (delivered == len_r - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? DONE : FETCH;
      FETCH:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FETCH) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      len_r       <= '0;
      issued      <= '0;
      delivered   <= '0;
      pipe        <= '0;
    end else begin
      pipe[0] <= issue;
      for (int k = 1; k < ROM_LAT; k++) pipe[k] <= pipe[k-1];
      if (start_ok) begin
        len_r     <= length;
        issued    <= '0;
        delivered <= '0;
        // A zero-length request leaves the address bus untouched.
        if (length != '0) rom_address <= base_addr;
      end
      if (issue) begin
        rom_address <= rom_address + 1'b1;
        issued      <= issued + 1'b1;
      end
      if (pop) delivered <= delivered + 1'b1;
    end
  end

`ifdef ROM_RD_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (pop)      checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a latency-accurate ROM model.
module tb_rom_burst_reader;
  import rom_rd_pkg::*;

  localparam int LAT   = DEF_ROM_LAT;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  count_t      length = '0;
  logic        busy;
  logic        done;
  logic [7:0]  rom_address;
  logic [31:0] rom_q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef ROM_RD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clock = ~clock;

  rom_burst_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef ROM_RD_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return 32'hA500_0000 | {24'h0, a};
  endfunction

  logic [31:0] rom_pipe [LAT];
  always @(posedge clock) begin
    rom_pipe[0] <= rom_word(rom_address);
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_pipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  logic [31:0] got [$];
  int          got_c [$];
  int          first_valid_c;
  int          done_c;
  int          done_cnt;
  logic        busy_after;
  logic        busy_mid;
  logic        valid_seen;
  logic        finished;
  logic [7:0]  addr_at10;
  logic [31:0] sum_at_done;

  // mode 0: ready always high; 1: ready low for 10 cycles; 2: ready toggles 1,0,1,0
  task automatic run_burst(input logic [7:0] b, input count_t l, input int mode);
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    got.delete();
    got_c.delete();
    first_valid_c = -1;
    done_c        = -1;
    done_cnt      = 0;
    valid_seen    = 1'b0;
    finished      = 1'b0;
    busy_after    = 1'bx;
    busy_mid      = 1'b0;
    addr_at10     = '0;
    sum_at_done   = '0;
    @(negedge clock);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    out_ready = (mode != 1);
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clock);
      case (mode)
        1:       out_ready = (c > 10);
        2:       out_ready = ((c % 2) == 1);
        default: out_ready = 1'b1;
      endcase
      if (c == 1) busy_mid = busy;
      if (prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_valid", out_valid, 1);
      end
      if (out_valid) valid_seen = 1'b1;
      if (out_valid && first_valid_c < 0) first_valid_c = c;
      if (c == 10) addr_at10 = rom_address;
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
`ifdef ROM_RD_CHECKSUM_EN
          sum_at_done = checksum;
`endif
        end
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_c.push_back(c);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_c > 0 && c == done_c + 1) begin
        busy_after = busy;
        finished   = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    check("burst_completed", finished, 1);
  endtask

  typedef struct {
    logic [7:0]  base;
    count_t      len;
    int          mode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          last;
    int          words;
    logic        any_done;
    logic        any_valid;
    logic [7:0]  a;
    logic [7:0]  addr_before;

    vecs[0] = '{8'h10, 9'd4,   0, 32'hA500_0010, 32'hA500_0013};
    vecs[1] = '{8'hFE, 9'd4,   0, 32'hA500_00FE, 32'hA500_0001};
    vecs[2] = '{8'h40, 9'd8,   1, 32'hA500_0040, 32'hA500_0047};
    vecs[3] = '{8'h01, 9'd3,   2, 32'hA500_0001, 32'hA500_0003};
    vecs[4] = '{8'h7F, 9'd1,   0, 32'hA500_007F, 32'hA500_007F};
    vecs[5] = '{8'h05, 9'd256, 0, 32'hA500_0005, 32'hA500_0004};

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rom_address", rom_address, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode);
      check("busy_during", busy_mid, 1);
      check("word_count", got.size(), 64'(vecs[v].len));
      for (int i = 0; i < got.size(); i++) begin
        a = vecs[v].base + 8'(i);
        check("word_data", got[i], rom_word(a));
      end
      if (got.size() == int'(vecs[v].len)) begin
        last = got.size() - 1;
        check("first_word", got[0], vecs[v].exp_first);
        check("last_word", got[last], vecs[v].exp_last);
        check("done_after_last", done_c, got_c[last] + 1);
        if (vecs[v].mode == 0) begin
          check("first_latency", first_valid_c, LAT + 2);
          check("back_to_back", got_c[last] - got_c[0], last);
        end
      end
      if (vecs[v].mode == 1) check("stall_rom_address", addr_at10, vecs[v].base + 8'(DEPTH));
      check("done_width", done_cnt, 1);
      check("busy_after_done", busy_after, 0);
    end

`ifdef ROM_RD_CHECKSUM_EN
    run_burst(8'h01, 9'd3, 2);
    check("checksum_words", got.size(), 3);
    check("checksum", sum_at_done, 32'hEF00_0006);
`endif

    addr_before = rom_address;
    run_burst(8'h33, 9'd0, 0);
    check("zero_len_words", got.size(), 0);
    check("zero_len_valid", valid_seen, 0);
    check("zero_len_rom_address", rom_address, addr_before);
    check("zero_len_done_timing", (done_c >= 1) && (done_c <= 2), 1);
    check("zero_len_done_width", done_cnt, 1);

    // Abort a long burst right after its second word is taken.
    @(negedge clock);
    start     = 1'b1;
    base_addr = 8'h20;
    length    = 9'd16;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    words = 0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid && out_ready) words++;
      if (words == 2) break;
      @(negedge clock);
    end
    check("abort_two_words", words, 2);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rom_address", rom_address, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    @(negedge clock);
    reset = 1'b0;
    any_done  = 1'b0;
    any_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      any_done  = any_done | done;
      any_valid = any_valid | out_valid;
    end
    check("abort_no_done", any_done, 0);
    check("abort_no_stale_data", any_valid, 0);

    run_burst(8'h00, 9'd2, 0);
    check("post_abort_count", got.size(), 2);
    if (got.size() == 2) begin
      check("post_abort_word0", got[0], 32'hA500_0000);
      check("post_abort_word1", got[1], 32'hA500_0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
